// File: rtl/cpu_ctrl_pkg.sv
// Shared control encodings for the multi-cycle RISC sequencer.
// Opcodes, FSM states, ALU op and error codes.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_STORE = 6'd3;
  localparam logic [5:0] OP_LOAD  = 6'd4;
  localparam logic [5:0] OP_HALT  = 6'd63;

  localparam logic [1:0] ALU_NONE = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  function automatic logic uses_mem(
    input logic [5:0] op
  );
    return (op == OP_STORE) ||
           (op == OP_LOAD);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Sequencer bus: start, instruction/data memory
// handshakes and datapath control strobes.
interface instr_sequencer_if #(
  parameter int IW   = 32,
  parameter int CNTW = 32
);
  logic            start;
  logic            im_req;
  logic            im_ack;
  logic [IW-1:0]   instr;
  logic            ir_we;
  logic [1:0]      alu_op;
  logic            rf_we;
  logic            dm_req;
  logic            dm_we;
  logic            dm_ack;
  logic            pc_inc;
  logic            halted;
  logic [1:0]      err;
  logic [CNTW-1:0] instr_cnt;

  modport master (
    input  start, im_ack, instr, dm_ack,
    output im_req, ir_we, alu_op, rf_we,
    output dm_req, dm_we, pc_inc, halted,
    output err, instr_cnt
  );

  modport slave (
    output start, im_ack, instr, dm_ack,
    input  im_req, ir_we, alu_op, rf_we,
    input  dm_req, dm_we, pc_inc, halted,
    input  err, instr_cnt
  );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Wait-cycle counter shared by the fetch and data
// memory waits; flags the last allowed wait cycle.
module ctrl_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tmo
);
  localparam int CW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_tmo = (r_cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// driving the RF, ALU, PC and memory strobes.
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int IW          = 32,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNTW        = 32
) (
  input logic                clk,
  input logic                reset,
  instr_sequencer_if.master  bus
);
  state_t          r_state;
  state_t          w_nxt;
  logic [5:0]      r_op;
  logic [1:0]      r_err;
  logic [1:0]      w_err_nxt;
  logic [CNTW-1:0] r_cnt;
  logic            w_tmo;
  logic            w_clr;
  logic            w_en;
  logic            w_ir_we;
  logic            w_pc_inc;
  logic            w_is_nop;
  logic            w_is_exe;
  logic            w_is_halt;
  logic            w_unused_instr;

  assign w_unused_instr = ^bus.instr[IW-7:0];

  assign w_is_nop  = (r_op == OP_NOP);
  assign w_is_halt = (r_op == OP_HALT);
  assign w_is_exe  = (r_op == OP_ADD) ||
                     (r_op == OP_SUB) ||
                     uses_mem(r_op);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_err   <= ERR_NONE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_err   <= w_err_nxt;
      if (w_ir_we)  r_op  <= bus.instr[IW-1 -: 6];
      if (w_pc_inc) r_cnt <= r_cnt + CNTW'(1);
    end
  end

  always_comb begin
    w_nxt       = r_state;
    w_err_nxt   = r_err;
    w_ir_we     = 1'b0;
    w_pc_inc    = 1'b0;
    w_en        = 1'b0;
    bus.im_req  = 1'b0;
    bus.dm_req  = 1'b0;
    bus.dm_we   = 1'b0;
    bus.rf_we   = 1'b0;
    bus.alu_op  = ALU_NONE;
    case (r_state)
      S_IDLE: begin
        if (bus.start) w_nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.im_req = 1'b1;
        if (bus.im_ack) begin
          w_ir_we = 1'b1;
          w_nxt   = S_DECODE;
        end else if (w_tmo) begin
          w_nxt     = S_HALT;
          w_err_nxt = ERR_TIMEOUT;
        end else begin
          w_en = 1'b1;
        end
      end
      S_DECODE: begin
        unique case (1'b1)
          w_is_nop: begin
            w_pc_inc = 1'b1;
            w_nxt    = S_FETCH;
          end
          w_is_exe:  w_nxt = S_EXEC;
          w_is_halt: begin
            w_nxt     = S_HALT;
            w_err_nxt = ERR_NONE;
          end
          default: begin
            w_nxt     = S_HALT;
            w_err_nxt = ERR_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        bus.alu_op = (r_op == OP_SUB) ?
                     ALU_SUB : ALU_ADD;
        w_nxt = uses_mem(r_op) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.dm_req = 1'b1;
        bus.dm_we  = (r_op == OP_STORE);
        if (bus.dm_ack) begin
          // STORE retires here; LOAD still writes back
          if (r_op == OP_STORE) begin
            w_pc_inc = 1'b1;
            w_nxt    = S_FETCH;
          end else begin
            w_nxt = S_WB;
          end
        end else if (w_tmo) begin
          w_nxt     = S_HALT;
          w_err_nxt = ERR_TIMEOUT;
        end else begin
          w_en = 1'b1;
        end
      end
      S_WB: begin
        bus.rf_we = 1'b1;
        w_pc_inc  = 1'b1;
        w_nxt     = S_FETCH;
      end
      S_HALT: w_nxt = S_HALT;
      default: w_nxt = S_IDLE;
    endcase
  end

  // any state change restarts the wait count
  assign w_clr = (w_nxt != r_state);

  ctrl_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_clr),
    .i_en  (w_en),
    .o_tmo (w_tmo)
  );

  assign bus.ir_we     = w_ir_we;
  assign bus.pc_inc    = w_pc_inc;
  assign bus.halted    = (r_state == S_HALT);
  assign bus.err       = r_err;
  assign bus.instr_cnt = r_cnt;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: memory responder,
// per-instruction scoreboard and corner sequences.
module tb_instr_sequencer;
  import cpu_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_sequencer_if #(.IW(32), .CNTW(32)) bus();

  instr_sequencer #(
    .IW          (32),
    .MEM_TIMEOUT (15),
    .CNTW        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int         id;
    logic [5:0] op;
    int         iw;
    int         dw;
    logic [1:0] alu;
    int         rf;
    int         dmr;
    int         dmw;
    int         cyc;
  } vec_t;

  vec_t tbl[10];
  vec_t sbq[$];
  vec_t cur;
  vec_t e;

  int errors = 0;
  int checks = 0;
  int iw_left, dw_left, pops;
  bit have_instr, push_en;
  int m_cyc, m_ir, m_rf, m_dmr, m_dmw, m_alun;
  logic [1:0] m_alu;
  bit m_act;
  logic [31:0] exp_cnt;
  int n, p, cnt;
  bit seen;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic clr_mon();
    m_cyc = 0; m_ir = 0; m_rf = 0;
    m_dmr = 0; m_dmw = 0; m_alun = 0;
    m_alu = 2'b00; m_act = 1'b0;
  endtask

  task automatic step(input bit st);
    @(negedge clk);
    bus.start  = st;
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    bus.instr  = $urandom;
    if (bus.im_req && have_instr) begin
      if (iw_left == 0) begin
        bus.im_ack = 1'b1;
        bus.instr  = {cur.op, 26'($urandom)};
        have_instr = 1'b0;
        if (push_en) sbq.push_back(cur);
      end else begin
        iw_left--;
      end
    end
    if (bus.dm_req) begin
      if (dw_left == 0) bus.dm_ack = 1'b1;
      else dw_left--;
    end
    #2;
    if (bus.im_req) m_act = 1'b1;
    if (m_act) begin
      m_cyc++;
      if (bus.ir_we) m_ir++;
      if (bus.rf_we) m_rf++;
      if (bus.dm_req) m_dmr++;
      if (bus.dm_req && bus.dm_we) m_dmw++;
      if (bus.alu_op != 2'b00) begin
        m_alun++;
        m_alu = bus.alu_op;
      end
    end
    if (bus.pc_inc) begin
      if (sbq.size() == 0) begin
        chk("pc_inc_unexpected", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("v%0d_cyc", e.id), m_cyc, e.cyc);
        chk($sformatf("v%0d_ir", e.id), m_ir, 1);
        chk($sformatf("v%0d_rf", e.id), m_rf, e.rf);
        chk($sformatf("v%0d_dmr", e.id), m_dmr, e.dmr);
        chk($sformatf("v%0d_dmw", e.id), m_dmw, e.dmw);
        chk($sformatf("v%0d_alu", e.id), m_alu, e.alu);
        chk($sformatf("v%0d_alun", e.id), m_alun,
            (e.alu != 2'b00) ? 1 : 0);
        chk($sformatf("v%0d_cnt", e.id),
            bus.instr_cnt, exp_cnt);
        exp_cnt++;
        pops++;
      end
      clr_mon();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    have_instr = 1'b0;
    sbq.delete();
    exp_cnt = '0;
    clr_mon();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_instr(input logic [5:0] op,
                            input int iw,
                            input int dw);
    cur.op = op;
    iw_left = iw;
    dw_left = dw;
    have_instr = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.im_ack = 1'b0;
    bus.dm_ack = 1'b0;
    bus.instr = '0;
    have_instr = 1'b0;
    push_en = 1'b1;
    pops = 0;
    exp_cnt = '0;
    clr_mon();

    //          id op       iw dw alu      rf dmr dmw cyc
    tbl[0] = '{0, OP_NOP,   1, 0, ALU_NONE, 0, 0,  0,  3};
    tbl[1] = '{1, OP_ADD,   2, 0, ALU_ADD,  1, 0,  0,  6};
    tbl[2] = '{2, OP_SUB,   1, 0, ALU_SUB,  1, 0,  0,  5};
    tbl[3] = '{3, OP_STORE, 1, 3, ALU_ADD,  0, 4,  4,  8};
    tbl[4] = '{4, OP_LOAD,  1, 0, ALU_ADD,  1, 1,  0,  6};
    tbl[5] = '{5, OP_LOAD,  0, 2, ALU_ADD,  1, 3,  0,  7};
    tbl[6] = '{6, OP_STORE, 0, 0, ALU_ADD,  0, 1,  1,  4};
    tbl[7] = '{7, OP_NOP,  14, 0, ALU_NONE, 0, 0,  0, 16};
    tbl[8] = '{8, OP_STORE, 1,14, ALU_ADD,  0, 15, 15,19};
    tbl[9] = '{9, OP_ADD,   0, 0, ALU_ADD,  1, 0,  0,  4};

    #12;
    chk("reset_outs",
        {bus.im_req, bus.ir_we, bus.alu_op,
         bus.rf_we, bus.dm_req, bus.dm_we,
         bus.pc_inc, bus.halted, bus.err,
         bus.instr_cnt}, '0);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1);

    for (int i = 0; i < 10; i++) begin
      cur = tbl[i];
      load_instr(tbl[i].op, tbl[i].iw, tbl[i].dw);
      p = pops;
      n = 0;
      while (pops == p && n < 200) begin
        step(1'b0);
        n++;
      end
      if (pops == p)
        chk($sformatf("v%0d_done", i), 0, 1);
    end
    step(1'b0);
    chk("queue_empty", sbq.size(), 0);
    chk("instr_cnt_total", bus.instr_cnt, 10);

    // abort in MEM with an async reset
    push_en = 1'b0;
    load_instr(OP_STORE, 0, 1000);
    n = 0;
    while (!bus.dm_req && n < 50) begin
      step(1'b0);
      n++;
    end
    chk("reached_mem", bus.dm_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("rst_dm_req", bus.dm_req, 0);
    chk("rst_dm_we", bus.dm_we, 0);
    chk("rst_cnt", bus.instr_cnt, 0);
    do_reset();
    step(1'b1);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      if (bus.im_req) seen = 1'b1;
    end
    chk("restart_fetch", seen, 1);

    // illegal opcode then start ignored
    load_instr(6'd7, 0, 0);
    repeat (6) step(1'b0);
    chk("ill_halted", bus.halted, 1);
    chk("ill_err", bus.err, ERR_ILLEGAL);
    cnt = 0;
    step(1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      if (bus.im_req) cnt++;
    end
    chk("ill_no_fetch", cnt, 0);
    chk("ill_still_halted", bus.halted, 1);

    // HALT opcode
    do_reset();
    step(1'b1);
    load_instr(OP_HALT, 1, 0);
    repeat (6) step(1'b0);
    chk("halt_halted", bus.halted, 1);
    chk("halt_err", bus.err, ERR_NONE);

    // fetch timeout
    do_reset();
    step(1'b1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0);
      if (bus.im_req) cnt++;
    end
    chk("imto_req_cycles", cnt, 15);
    chk("imto_halted", bus.halted, 1);
    chk("imto_err", bus.err, ERR_TIMEOUT);

    // data-memory timeout on STORE
    do_reset();
    step(1'b1);
    load_instr(OP_STORE, 0, 1000);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b0);
      if (bus.dm_req) cnt++;
    end
    chk("dmto_req_cycles", cnt, 15);
    chk("dmto_halted", bus.halted, 1);
    chk("dmto_err", bus.err, ERR_TIMEOUT);
    chk("dmto_cnt", bus.instr_cnt, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
